// File: rtl/fade_pkg.sv
// Shared types and helpers for the LED fade engine: default sizes, sweep FSM
// states, channel index type and the perceptual gamma map used under FADE_GAMMA_EN.
package fade_pkg;

  localparam int NCH_DEF = 8;
  localparam int W_DEF   = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } fade_state_e;

  typedef logic [$clog2(NCH_DEF)-1:0] ch_idx_t;

  // Quadratic map (c*c)>>W, keeping any nonzero input visibly lit.
  function automatic logic [W_DEF-1:0] gamma_map(input logic [W_DEF-1:0] c);
    logic [2*W_DEF-1:0] prod;
    logic [W_DEF-1:0]   g;
    prod = c * c;
    g    = prod[2*W_DEF-1:W_DEF];
    if ((c != '0) && (g == '0)) begin
      g = {{(W_DEF-1){1'b0}}, 1'b1};
    end
    return g;
  endfunction

endpackage

// File: rtl/fade_step.sv
// Combinational saturating step: moves cur toward tgt by at most step,
// never overshooting tgt and never wrapping outside 0..2^W-1.
module fade_step
  import fade_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] cur,
  input  logic [W-1:0] tgt,
  input  logic [W-1:0] step,
  output logic [W-1:0] next_cur
);

  logic        [W:0] up_sum;
  logic signed [W:0] dn_dif;

  assign up_sum = {1'b0, cur} + {1'b0, step};
  assign dn_dif = $signed({1'b0, cur}) - $signed({1'b0, step});

  always_comb begin
    next_cur = cur;
    if (cur < tgt) begin
      next_cur = (up_sum >= {1'b0, tgt}) ? tgt : up_sum[W-1:0];
    end else if (cur > tgt) begin
      next_cur = (dn_dif <= $signed({1'b0, tgt})) ? tgt : dn_dif[W-1:0];
    end
  end

endmodule

// File: rtl/led_fade_engine.sv
// Per-channel brightness fader: a prescaler tick launches a sweep that steps one
// channel per clock through a shared fade_step unit. FADE_GAMMA_EN adds a gamma stage.
module led_fade_engine
  import fade_pkg::*;
#(
  parameter int NCH   = NCH_DEF,
  parameter int W     = W_DEF,
  parameter int DIV_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic                     wr_snap,
  input  logic [$clog2(NCH)-1:0]   wr_ch,
  input  logic [W-1:0]             wr_data,
  input  logic [DIV_W-1:0]         tick_div,
  input  logic [W-1:0]             step,
  output logic [NCH*W-1:0]         level_out,
  output logic                     busy,
  output logic                     settled,
  output logic                     overrun
);

  localparam int CW = $clog2(NCH);
  localparam logic [CW-1:0] LAST_CH = CW'(NCH - 1);

  logic [W-1:0]     tgt_q [NCH];
  logic [W-1:0]     tgt_d [NCH];
  logic [W-1:0]     cur_q [NCH];
  logic [W-1:0]     cur_d [NCH];
  logic [DIV_W-1:0] presc_q, presc_d;
  fade_state_e      state_q, state_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             overrun_q, overrun_d;
  logic             tick;
  logic [W-1:0]     step_cur;

  assign tick    = (presc_q == tick_div);
  assign presc_d = tick ? '0 : presc_q + DIV_W'(1);

  fade_step #(.W(W)) u_step (
    .cur      (cur_q[idx_q]),
    .tgt      (tgt_q[idx_q]),
    .step     (step),
    .next_cur (step_cur)
  );

  // A tick on the final sweep cycle chains straight into the next sweep, so
  // tick_div >= NCH-1 never overruns.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SWEEP;
          idx_d   = '0;
        end
      end
      SWEEP: begin
        if (idx_q == LAST_CH) begin
          idx_d = '0;
          if (!tick) begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + CW'(1);
          if (tick) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sweep reads the pre-write target; a snap overrides the sweep result.
  always_comb begin
    tgt_d = tgt_q;
    cur_d = cur_q;
    if (state_q == SWEEP) begin
      cur_d[idx_q] = step_cur;
    end
    if (wr_en) begin
      tgt_d[wr_ch] = wr_data;
      if (wr_snap) begin
        cur_d[wr_ch] = wr_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        tgt_q[i] <= '0;
        cur_q[i] <= '0;
      end
      presc_q   <= '0;
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      tgt_q     <= tgt_d;
      cur_q     <= cur_d;
      presc_q   <= presc_d;
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    settled = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      settled = settled & (cur_q[i] == tgt_q[i]);
    end
  end

  assign busy    = (state_q == SWEEP);
  assign overrun = overrun_q;

`ifdef FADE_GAMMA_EN
  logic [W-1:0] lvl_q [NCH];
  logic [W-1:0] lvl_d [NCH];

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      lvl_d[i] = gamma_map(cur_q[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        lvl_q[i] <= '0;
      end
    end else begin
      lvl_q <= lvl_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      level_out[i*W +: W] = lvl_q[i];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      level_out[i*W +: W] = cur_q[i];
    end
  end
`endif

endmodule
